// File: rtl/collision_engine.sv
// rtl/collision_engine.sv - Pac-Man item and ghost collision resolver, one ghost per cycle
// Optional pass-through (tile swap) detection is enabled by defining COLLISION_SWAP_DETECT_EN.
module collision_engine #(
  parameter int NUM_GHOSTS = 4,
  parameter int COORD_W    = 6,
  parameter int STATE_W    = 4,
  parameter logic [STATE_W-1:0] ST_FRIGHT = STATE_W'(2),
  parameter logic [STATE_W-1:0] ST_EYES   = STATE_W'(3)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_play,
  input  logic                          i_tick,
  input  logic [COORD_W-1:0]            i_pacman_x,
  input  logic [COORD_W-1:0]            i_pacman_y,
  input  logic [NUM_GHOSTS*COORD_W-1:0] i_ghost_x,
  input  logic [NUM_GHOSTS*COORD_W-1:0] i_ghost_y,
  input  logic [NUM_GHOSTS*STATE_W-1:0] i_ghost_state,
  output logic                          o_item_rd_en,
  output logic [COORD_W-1:0]            o_item_x,
  output logic [COORD_W-1:0]            o_item_y,
  input  logic [1:0]                    i_item_rd_data,
  output logic                          o_item_clr,
  output logic                          o_item_eaten,
  output logic [1:0]                    o_item_type,
  output logic [NUM_GHOSTS-1:0]         o_ghost_eaten,
  output logic [10:0]                   o_ghost_points,
  output logic                          o_pacman_eaten,
  output logic                          o_busy
);

  localparam logic [1:0] I_NONE      = 2'd0;
  localparam logic [1:0] I_DOT       = 2'd1;
  localparam logic [1:0] I_ENERGIZER = 2'd2;
  localparam int IDX_W = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GHOSTS - 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_ITEM, S_GHOST, S_DEAD} state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [1:0]         combo;
  logic [COORD_W-1:0] px, py;
  logic [COORD_W-1:0] gx [NUM_GHOSTS];
  logic [COORD_W-1:0] gy [NUM_GHOSTS];
  logic [STATE_W-1:0] gst [NUM_GHOSTS];

  logic               accept;
  logic [COORD_W-1:0] cur_gx, cur_gy;
  logic [STATE_W-1:0] cur_st;
  logic               same_tile, swap_hit, hit;

  assign accept    = (state == S_IDLE) && i_tick && i_play;
  assign cur_gx    = gx[idx];
  assign cur_gy    = gy[idx];
  assign cur_st    = gst[idx];
  assign same_tile = (cur_gx == px) && (cur_gy == py);
  assign hit       = same_tile || swap_hit;
  assign o_item_x  = px;
  assign o_item_y  = py;
  assign o_busy    = (state != S_IDLE);

`ifdef COLLISION_SWAP_DETECT_EN
  // Previous tiles shift in on every accepted tick; swap_en marks that they hold a real tile.
  logic [COORD_W-1:0] ppx, ppy;
  logic [COORD_W-1:0] gpx [NUM_GHOSTS];
  logic [COORD_W-1:0] gpy [NUM_GHOSTS];
  logic               prev_valid, swap_en;

  assign swap_hit = swap_en && (cur_gx == ppx) && (cur_gy == ppy) &&
                    (gpx[idx] == px) && (gpy[idx] == py);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_valid <= 1'b0;
      swap_en    <= 1'b0;
      ppx        <= '0;
      ppy        <= '0;
      for (int k = 0; k < NUM_GHOSTS; k++) begin
        gpx[k] <= '0;
        gpy[k] <= '0;
      end
    end else if (accept) begin
      swap_en    <= prev_valid;
      prev_valid <= 1'b1;
      ppx        <= px;
      ppy        <= py;
      for (int k = 0; k < NUM_GHOSTS; k++) begin
        gpx[k] <= gx[k];
        gpy[k] <= gy[k];
      end
    end
  end
`else
  assign swap_hit = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= S_IDLE;
      idx            <= '0;
      combo          <= '0;
      px             <= '0;
      py             <= '0;
      o_item_rd_en   <= 1'b0;
      o_item_clr     <= 1'b0;
      o_item_eaten   <= 1'b0;
      o_item_type    <= I_NONE;
      o_ghost_eaten  <= '0;
      o_ghost_points <= '0;
      o_pacman_eaten <= 1'b0;
      for (int k = 0; k < NUM_GHOSTS; k++) begin
        gx[k]  <= '0;
        gy[k]  <= '0;
        gst[k] <= '0;
      end
    end else begin
      o_item_rd_en   <= 1'b0;
      o_item_clr     <= 1'b0;
      o_item_eaten   <= 1'b0;
      o_item_type    <= I_NONE;
      o_ghost_eaten  <= '0;
      o_ghost_points <= '0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            px <= i_pacman_x;
            py <= i_pacman_y;
            for (int k = 0; k < NUM_GHOSTS; k++) begin
              gx[k]  <= i_ghost_x[k*COORD_W +: COORD_W];
              gy[k]  <= i_ghost_y[k*COORD_W +: COORD_W];
              gst[k] <= i_ghost_state[k*STATE_W +: STATE_W];
            end
            o_item_rd_en <= 1'b1;
            state        <= S_READ;
          end
        end
        S_READ: begin
          state <= i_play ? S_ITEM : S_IDLE;
        end
        S_ITEM: begin
          if (!i_play) begin
            state <= S_IDLE;
          end else begin
            if (i_item_rd_data == I_DOT || i_item_rd_data == I_ENERGIZER) begin
              o_item_eaten <= 1'b1;
              o_item_clr   <= 1'b1;
              o_item_type  <= i_item_rd_data;
            end
            if (i_item_rd_data == I_ENERGIZER) combo <= '0;
            idx   <= '0;
            state <= S_GHOST;
          end
        end
        S_GHOST: begin
          if (!i_play) begin
            state <= S_IDLE;
          end else if (hit && cur_st != ST_FRIGHT && cur_st != ST_EYES) begin
            o_pacman_eaten <= 1'b1;
            state          <= S_DEAD;
          end else begin
            if (hit && cur_st == ST_FRIGHT) begin
              o_ghost_eaten[idx] <= 1'b1;
              o_ghost_points     <= 11'd200 << combo;
              if (combo != 2'd3) combo <= combo + 2'd1;
            end
            if (idx == LAST_IDX) state <= S_IDLE;
            else                 idx   <= idx + 1'b1;
          end
        end
        S_DEAD: begin
          if (!i_play) begin
            o_pacman_eaten <= 1'b0;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_engine.sv
// tb/tb_collision_engine.sv - directed bench for collision_engine with a pass-planning model
module tb_collision_engine;
  localparam int N = 4, CW = 6, SW = 4, MAXC = 4096;
  localparam logic [1:0] I_NONE = 2'd0, I_DOT = 2'd1, I_EN = 2'd2;
  localparam logic [3:0] ST_CHASE = 4'd0, ST_FR = 4'd2, ST_EY = 4'd3;
`ifdef COLLISION_SWAP_DETECT_EN
  localparam bit SWAP_ON = 1'b1;
`else
  localparam bit SWAP_ON = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, play = 1'b0, tick = 1'b0;
  logic [CW-1:0] pxi, pyi;
  logic [N*CW-1:0] gxv, gyv;
  logic [N*SW-1:0] gsv;
  logic o_item_rd_en, o_item_clr, o_item_eaten, o_pacman_eaten, o_busy;
  logic [CW-1:0] o_item_x, o_item_y;
  logic [1:0] o_item_type;
  logic [N-1:0] o_ghost_eaten;
  logic [10:0] o_ghost_points;
  logic [1:0] item_q = 2'd0;
  logic [1:0] ram [64][64];

  int cyc = 0, total = 0, bad = 0, t = 0;
  bit chk_en = 1'b0;

  logic [CW-1:0] sx, sy;
  logic [CW-1:0] gx_s [N];
  logic [CW-1:0] gy_s [N];
  logic [SW-1:0] gs_s [N];

  bit          e_rd [MAXC], e_clr [MAXC], e_eat [MAXC], e_pac [MAXC], e_busy [MAXC];
  logic [1:0]  e_type [MAXC];
  logic [N-1:0] e_gh [MAXC];
  logic [10:0] e_pts [MAXC];
  logic [CW-1:0] e_x [MAXC], e_y [MAXC];

  int m_combo = 0, m_t0 = 0, m_dc = 0;
  bit m_have = 1'b0;
  logic [CW-1:0] m_px = '0, m_py = '0, m_ppx = '0, m_ppy = '0;
  logic [CW-1:0] m_gx [N], m_gy [N], m_pgx [N], m_pgy [N];
  logic [SW-1:0] m_gs [N];

  collision_engine dut (
    .i_clk(clk), .i_rst(rst), .i_play(play), .i_tick(tick),
    .i_pacman_x(pxi), .i_pacman_y(pyi),
    .i_ghost_x(gxv), .i_ghost_y(gyv), .i_ghost_state(gsv),
    .o_item_rd_en(o_item_rd_en), .o_item_x(o_item_x), .o_item_y(o_item_y),
    .i_item_rd_data(item_q), .o_item_clr(o_item_clr), .o_item_eaten(o_item_eaten),
    .o_item_type(o_item_type), .o_ghost_eaten(o_ghost_eaten),
    .o_ghost_points(o_ghost_points), .o_pacman_eaten(o_pacman_eaten), .o_busy(o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (o_item_rd_en) item_q <= ram[o_item_x][o_item_y];
    if (o_item_clr) ram[o_item_x][o_item_y] = I_NONE;
  end

  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      total++;
      if (o_item_rd_en !== e_rd[cyc] || o_item_clr !== e_clr[cyc] || o_item_eaten !== e_eat[cyc] ||
          o_item_type !== e_type[cyc] || o_ghost_eaten !== e_gh[cyc] || o_ghost_points !== e_pts[cyc] ||
          o_pacman_eaten !== e_pac[cyc] || o_busy !== e_busy[cyc] ||
          ((e_rd[cyc] || e_clr[cyc]) && (o_item_x !== e_x[cyc] || o_item_y !== e_y[cyc]))) begin
        bad++;
        $display("FAIL cycle%0d outputs: got rd=%0d clr=%0d eat=%0d type=%0d gh=%b pts=%0d pac=%0d busy=%0d x=%0d y=%0d want rd=%0d clr=%0d eat=%0d type=%0d gh=%b pts=%0d pac=%0d busy=%0d x=%0d y=%0d",
                 cyc, o_item_rd_en, o_item_clr, o_item_eaten, o_item_type, o_ghost_eaten, o_ghost_points,
                 o_pacman_eaten, o_busy, o_item_x, o_item_y, e_rd[cyc], e_clr[cyc], e_eat[cyc], e_type[cyc],
                 e_gh[cyc], e_pts[cyc], e_pac[cyc], e_busy[cyc], e_x[cyc], e_y[cyc]);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic goto(input int c);
    int guard = 0;
    while (cyc < c && guard < MAXC) begin
      @(posedge clk);
      #1;
      guard++;
    end
  endtask

  task automatic drive();
    pxi = sx;
    pyi = sy;
    for (int k = 0; k < N; k++) begin
      gxv[k*CW +: CW] = gx_s[k];
      gyv[k*CW +: CW] = gy_s[k];
      gsv[k*SW +: SW] = gs_s[k];
    end
  endtask

  task automatic ghosts_far();
    for (int k = 0; k < N; k++) begin
      gx_s[k] = 6'd60;
      gy_s[k] = CW'(k);
      gs_s[k] = ST_CHASE;
    end
  endtask

  // Expected output timeline of one accepted pass; ab>0 means i_play drops in cycle t0+ab.
  task automatic plan(input int t0, input int ab);
    bit sw, died, same, swp;
    int c, endc;
    logic [1:0] code;
    sw = m_have;
    m_ppx = m_px;
    m_ppy = m_py;
    for (int k = 0; k < N; k++) begin
      m_pgx[k] = m_gx[k];
      m_pgy[k] = m_gy[k];
      m_gx[k]  = gx_s[k];
      m_gy[k]  = gy_s[k];
      m_gs[k]  = gs_s[k];
    end
    m_px = sx;
    m_py = sy;
    m_have = 1'b1;
    m_t0 = t0;
    code = ram[sx][sy];
    e_rd[t0+1] = 1'b1;
    e_x[t0+1] = sx;
    e_y[t0+1] = sy;
    if ((ab == 0 || ab > 2) && (code == I_DOT || code == I_EN)) begin
      e_clr[t0+3] = 1'b1;
      e_eat[t0+3] = 1'b1;
      e_type[t0+3] = code;
      e_x[t0+3] = sx;
      e_y[t0+3] = sy;
      if (code == I_EN) m_combo = 0;
    end
    died = 1'b0;
    endc = t0 + 3 + N;
    for (int k = 0; k < N; k++) begin
      c = t0 + 3 + k;
      if (ab != 0 && c >= t0 + ab) break;
      same = (m_gx[k] == m_px) && (m_gy[k] == m_py);
      swp = SWAP_ON && sw && (m_gx[k] == m_ppx) && (m_gy[k] == m_ppy) && (m_pgx[k] == m_px) && (m_pgy[k] == m_py);
      if (same || swp) begin
        if (m_gs[k] == ST_FR) begin
          e_gh[c+1] = N'(1 << k);
          e_pts[c+1] = 11'(200 << m_combo);
          if (m_combo < 3) m_combo++;
        end else if (m_gs[k] != ST_EY) begin
          died = 1'b1;
          m_dc = c + 1;
          break;
        end
      end
    end
    if (died) begin
      for (int j = t0 + 1; j < MAXC; j++) e_busy[j] = 1'b1;
      for (int j = m_dc; j < MAXC; j++) e_pac[j] = 1'b1;
    end else begin
      if (ab != 0 && t0 + ab + 1 < endc) endc = t0 + ab + 1;
      for (int j = t0 + 1; j < endc; j++) e_busy[j] = 1'b1;
    end
  endtask

  task automatic release_dead(input int d);
    for (int j = d + 1; j < MAXC; j++) begin
      e_busy[j] = 1'b0;
      e_pac[j] = 1'b0;
    end
  endtask

  task automatic model_reset(input int r);
    for (int j = r + 1; j < MAXC; j++) begin
      e_rd[j] = 0; e_clr[j] = 0; e_eat[j] = 0; e_pac[j] = 0; e_busy[j] = 0;
      e_type[j] = I_NONE; e_gh[j] = '0; e_pts[j] = '0;
    end
    m_combo = 0;
    m_have = 1'b0;
  endtask

  task automatic do_tick(input int ab, output int t0);
    drive();
    t0 = cyc;
    tick = 1'b1;
    plan(t0, ab);
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  initial begin
    logic [3:0] want_sw;
    for (int j = 0; j < MAXC; j++) begin
      e_rd[j] = 0; e_clr[j] = 0; e_eat[j] = 0; e_pac[j] = 0; e_busy[j] = 0;
      e_type[j] = I_NONE; e_gh[j] = '0; e_pts[j] = '0; e_x[j] = '0; e_y[j] = '0;
    end
    for (int a = 0; a < 64; a++)
      for (int b = 0; b < 64; b++) ram[a][b] = I_NONE;
    for (int k = 0; k < N; k++) begin
      m_gx[k] = '0; m_gy[k] = '0; m_pgx[k] = '0; m_pgy[k] = '0; m_gs[k] = '0;
    end
    sx = '0; sy = '0;
    ghosts_far();
    drive();
    goto(3);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_type", 32'(o_item_type), 32'(I_NONE));
    chk("rst_pac", 32'(o_pacman_eaten), 32'd0);
    play = 1'b1;

    // 1: dot at (13,26)
    ram[13][26] = I_DOT; sx = 6'd13; sy = 6'd26;
    goto(5);
    do_tick(0, t);
    chk("t1_rd_en", 32'(o_item_rd_en), 32'd1);
    chk("t1_addr", 32'({o_item_x, o_item_y}), 32'({6'd13, 6'd26}));
    goto(t + 3);
    chk("t1_eaten", 32'(o_item_eaten), 32'd1);
    chk("t1_type", 32'(o_item_type), 32'(I_DOT));
    goto(t + 8);

    // 2: energizer, ghosts 1 and 2 frightened on the tile, then ghost3 on a later pass
    ram[20][10] = I_EN; sx = 6'd20; sy = 6'd10;
    gx_s[1] = 6'd20; gy_s[1] = 6'd10; gs_s[1] = ST_FR;
    gx_s[2] = 6'd20; gy_s[2] = 6'd10; gs_s[2] = ST_FR;
    do_tick(0, t);
    goto(t + 5);
    chk("t2_gh1", 32'(o_ghost_eaten), 32'b0010);
    chk("t2_pts200", 32'(o_ghost_points), 32'd200);
    goto(t + 6);
    chk("t2_gh2", 32'(o_ghost_eaten), 32'b0100);
    chk("t2_pts400", 32'(o_ghost_points), 32'd400);
    goto(t + 9);
    ghosts_far();
    sx = 6'd30; sy = 6'd30;
    gx_s[3] = 6'd30; gy_s[3] = 6'd30; gs_s[3] = ST_FR;
    do_tick(0, t);
    goto(t + 7);
    chk("t2_gh3", 32'(o_ghost_eaten), 32'b1000);
    chk("t2_pts800", 32'(o_ghost_points), 32'd800);
    goto(t + 9);

    // 3: eyes ghost0 harmless, chase ghost2 kills, ghost3 never reached
    ghosts_far();
    sx = 6'd40; sy = 6'd40;
    gx_s[0] = 6'd40; gy_s[0] = 6'd40; gs_s[0] = ST_EY;
    gx_s[2] = 6'd40; gy_s[2] = 6'd40; gs_s[2] = ST_CHASE;
    gx_s[3] = 6'd40; gy_s[3] = 6'd40; gs_s[3] = ST_FR;
    do_tick(0, t);
    goto(t + 5);
    chk("t3_pre_pac", 32'(o_pacman_eaten), 32'd0);
    goto(t + 6);
    chk("t3_pac", 32'(o_pacman_eaten), 32'd1);
    goto(t + 7);
    chk("t3_no_gh3", 32'(o_ghost_eaten), 32'd0);
    goto(t + 10);
    play = 1'b0;
    release_dead(t + 10);
    goto(t + 11);
    chk("t3_pac_clr", 32'(o_pacman_eaten), 32'd0);
    chk("t3_idle", 32'(o_busy), 32'd0);
    play = 1'b1;
    ghosts_far();
    goto(t + 13);

    // 4a: second tick while busy ignored; combo saturated at 3 scores 1600
    sx = 6'd50; sy = 6'd50; ram[50][50] = I_DOT;
    gx_s[1] = 6'd50; gy_s[1] = 6'd50; gs_s[1] = ST_FR;
    do_tick(0, t);
    sx = 6'd1; sy = 6'd1;
    drive();
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    chk("t4_busy", 32'(o_busy), 32'd1);
    goto(t + 5);
    chk("t4_pts1600", 32'(o_ghost_points), 32'd1600);
    goto(t + 10);
    ghosts_far();

    // 4b: i_play low in cycle 2 aborts the pass
    sx = 6'd52; sy = 6'd52; ram[52][52] = I_DOT;
    gx_s[0] = 6'd52; gy_s[0] = 6'd52; gs_s[0] = ST_FR;
    do_tick(2, t);
    goto(t + 2);
    play = 1'b0;
    goto(t + 3);
    chk("t4_abort_item", 32'(o_item_eaten), 32'd0);
    chk("t4_abort_idle", 32'(o_busy), 32'd0);
    goto(t + 4);
    play = 1'b1;
    goto(t + 8);
    ghosts_far();

    // 5: Pac-Man and ghost0 swap tiles across two ticks
    sx = 6'd5; sy = 6'd5;
    gx_s[0] = 6'd6; gy_s[0] = 6'd5; gs_s[0] = ST_FR;
    do_tick(0, t);
    goto(t + 9);
    sx = 6'd6; sy = 6'd5;
    gx_s[0] = 6'd5; gy_s[0] = 6'd5;
    do_tick(0, t);
    goto(t + 4);
    want_sw = SWAP_ON ? 4'b0001 : 4'b0000;
    chk("t5_swap", 32'(o_ghost_eaten), 32'(want_sw));
    goto(t + 9);
    ghosts_far();

    // 6: reset mid-GHOST with combo=2
    ram[33][33] = I_EN; sx = 6'd33; sy = 6'd33;
    gx_s[0] = 6'd33; gy_s[0] = 6'd33; gs_s[0] = ST_FR;
    gx_s[1] = 6'd33; gy_s[1] = 6'd33; gs_s[1] = ST_FR;
    do_tick(0, t);
    goto(t + 9);
    ghosts_far();
    sx = 6'd34; sy = 6'd34;
    gx_s[3] = 6'd34; gy_s[3] = 6'd34; gs_s[3] = ST_FR;
    do_tick(0, t);
    goto(t + 4);
    rst = 1'b1;
    model_reset(t + 4);
    goto(t + 5);
    rst = 1'b0;
    chk("t6_rst_busy", 32'(o_busy), 32'd0);
    chk("t6_rst_pts", 32'(o_ghost_points), 32'd0);
    goto(t + 7);
    chk("t6_rst_gh", 32'(o_ghost_eaten), 32'd0);
    ghosts_far();
    gx_s[0] = 6'd34; gy_s[0] = 6'd34; gs_s[0] = ST_FR;
    goto(t + 9);
    do_tick(0, t);
    goto(t + 4);
    chk("t6_gh0", 32'(o_ghost_eaten), 32'b0001);
    chk("t6_pts200", 32'(o_ghost_points), 32'd200);
    goto(t + 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
